// File: rtl/dust16_bus_pkg.sv
// dust16_bus_pkg
// Shared definitions for the Dust16 byte-wide memory bus arbiter:
//   state_e          - arbiter sequencer states (IDLE, ACCESS, DONE)
//   PORT_CORE/AUX    - port identifiers used for grant and last
//   MEM_LAT_MIN/MAX  - legal range for the memory latency parameter
//   CNT_W            - width of the access cycle counter
package dust16_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_e;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_AUX  = 1'b1;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 15;
   localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles both master ports and the memory-side port of the Dust16 arbiter.
//   p0_* / p1_*  - req/wr/addr/outdata from a master, indata/wait back to it
//   m_*          - strobe, write, address and data to the memory, m_indata back
// Modports:
//   slave  - the arbiter's view (takes master requests, drives the memory)
//   master - the surrounding system's view (masters plus memory model)
interface mem_arbiter_if #(
   parameter int ADR_TOP = 15
);
   logic             p0_req;
   logic             p0_wr;
   logic [ADR_TOP:0] p0_addr;
   logic [7:0]       p0_outdata;
   logic [7:0]       p0_indata;
   logic             p0_wait;

   logic             p1_req;
   logic             p1_wr;
   logic [ADR_TOP:0] p1_addr;
   logic [7:0]       p1_outdata;
   logic [7:0]       p1_indata;
   logic             p1_wait;

   logic             m_req;
   logic             m_wr;
   logic [ADR_TOP:0] m_addr;
   logic [7:0]       m_outdata;
   logic [7:0]       m_indata;

   modport slave (
      input  p0_req, p0_wr, p0_addr, p0_outdata,
      output p0_indata, p0_wait,
      input  p1_req, p1_wr, p1_addr, p1_outdata,
      output p1_indata, p1_wait,
      output m_req, m_wr, m_addr, m_outdata,
      input  m_indata
   );

   modport master (
      output p0_req, p0_wr, p0_addr, p0_outdata,
      input  p0_indata, p0_wait,
      output p1_req, p1_wr, p1_addr, p1_outdata,
      input  p1_indata, p1_wait,
      input  m_req, m_wr, m_addr, m_outdata,
      output m_indata
   );

endinterface

// File: rtl/rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin picker.
//   req[1:0] - request from port 1 (bit 1) and port 0 (bit 0)
//   last     - port granted most recently
//   valid    - at least one request present
//   grant    - chosen port; on a tie the port that was not served last wins
module rr_pick2
   import dust16_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       valid,
   output logic       grant
);

   // Pick the requesting port, alternating on a tie
   always_comb begin
      valid = 1'b0;
      grant = PORT_CORE;
      case (req)
         2'b00: begin
            valid = 1'b0;
            grant = PORT_CORE;
         end
         2'b01: begin
            valid = 1'b1;
            grant = PORT_CORE;
         end
         2'b10: begin
            valid = 1'b1;
            grant = PORT_AUX;
         end
         2'b11: begin
            valid = 1'b1;
            grant = ~last;
         end
         default: begin
            valid = 1'b0;
            grant = PORT_CORE;
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port round-robin arbiter and sequencer for the Dust16 memory bus.
// A granted transfer strobes a fixed-latency memory for MEM_LAT cycles, then
// spends one DONE cycle in which the granted master sees wait low.
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - mem_arbiter_if.slave: both master ports and the memory port
// Parameters:
//   ADR_TOP - top bit of every address bus
//   MEM_LAT - memory access cycles per transfer, 1..15
module mem_arbiter
   import dust16_bus_pkg::*;
#(
   parameter int ADR_TOP = 15,
   parameter int MEM_LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_bad_lat
      $error("mem_arbiter: MEM_LAT must lie in 1..15");
   end

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   state_e           state_r;
   logic             grant_r;
   logic             last_r;
   logic [CNT_W-1:0] cnt_r;
   logic             m_req_r;
   logic             m_wr_r;
   logic [ADR_TOP:0] m_addr_r;
   logic [7:0]       m_outdata_r;
   logic [7:0]       p0_indata_r;
   logic [7:0]       p1_indata_r;

   logic             pick_valid_s;
   logic             pick_grant_s;
   logic             sel_wr_s;
   logic [ADR_TOP:0] sel_addr_s;
   logic [7:0]       sel_outdata_s;
   logic             granted_req_s;
   logic             done_s;

   rr_pick2 u_pick (
      .req   ({bus.p1_req, bus.p0_req}),
      .last  (last_r),
      .valid (pick_valid_s),
      .grant (pick_grant_s)
   );

   // Steer the picked port's command fields and the granted port's live request
   always_comb begin
      sel_wr_s      = bus.p0_wr;
      sel_addr_s    = bus.p0_addr;
      sel_outdata_s = bus.p0_outdata;
      granted_req_s = bus.p0_req;
      if (pick_grant_s == PORT_AUX) begin
         sel_wr_s      = bus.p1_wr;
         sel_addr_s    = bus.p1_addr;
         sel_outdata_s = bus.p1_outdata;
      end else begin
         sel_wr_s      = bus.p0_wr;
         sel_addr_s    = bus.p0_addr;
         sel_outdata_s = bus.p0_outdata;
      end
      if (grant_r == PORT_AUX) begin
         granted_req_s = bus.p1_req;
      end else begin
         granted_req_s = bus.p0_req;
      end
   end

   assign done_s = (state_r == DONE);

   // Wait is released only for the granted port during its completion cycle
   assign bus.p0_wait   = bus.p0_req & ~(done_s & (grant_r == PORT_CORE));
   assign bus.p1_wait   = bus.p1_req & ~(done_s & (grant_r == PORT_AUX));

   assign bus.m_req     = m_req_r;
   assign bus.m_wr      = m_wr_r;
   assign bus.m_addr    = m_addr_r;
   assign bus.m_outdata = m_outdata_r;
   assign bus.p0_indata = p0_indata_r;
   assign bus.p1_indata = p1_indata_r;

   // Sequencer: arbitrate in IDLE, count the memory access, then complete
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         grant_r     <= PORT_CORE;
         last_r      <= PORT_AUX;
         cnt_r       <= {CNT_W{1'b0}};
         m_req_r     <= 1'b0;
         m_wr_r      <= 1'b0;
         m_addr_r    <= {(ADR_TOP+1){1'b0}};
         m_outdata_r <= 8'h00;
         p0_indata_r <= 8'h00;
         p1_indata_r <= 8'h00;
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_valid_s) begin
                  grant_r     <= pick_grant_s;
                  last_r      <= pick_grant_s;
                  m_req_r     <= 1'b1;
                  m_wr_r      <= sel_wr_s;
                  m_addr_r    <= sel_addr_s;
                  m_outdata_r <= sel_outdata_s;
                  cnt_r       <= CNT_LOAD;
                  state_r     <= ACCESS;
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               if (cnt_r == {CNT_W{1'b0}}) begin
                  // A master that gave up its request mid-access gets no data
                  if (!m_wr_r && granted_req_s) begin
                     if (grant_r == PORT_AUX) begin
                        p1_indata_r <= bus.m_indata;
                     end else begin
                        p0_indata_r <= bus.m_indata;
                     end
                  end
                  m_req_r <= 1'b0;
                  m_wr_r  <= 1'b0;
                  state_r <= DONE;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               m_req_r <= 1'b0;
               m_wr_r  <= 1'b0;
               cnt_r   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

endmodule
